regfile: RTL and testbench
==========================

# regfile

- 32 x 32-bit RISC-V integer register file.
- Responder to the decode stage: serves its two combinational read requests and accepts one write-back write per cycle.
- Zeroes its storage sequentially after reset so it can map to FPGA distributed RAM.
- Provides a request/acknowledge debug port for reading or writing any register while the core runs.

## Interface
Parameters:
- INIT_FIRST, 1: first register index cleared by the init sweep (x0 is never stored).
- INIT_LAST, 31: last register index cleared by the init sweep.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous, active-low (`RstEnable` = 1'b0).
- reg1_raddr_i  in  5  read port 1 address.
- reg1_re_i  in  1  read port 1 enable.
- reg1_rdata_o  out  32  read port 1 data, combinational.
- reg2_raddr_i  in  5  read port 2 address.
- reg2_re_i  in  1  read port 2 enable.
- reg2_rdata_o  out  32  read port 2 data, combinational.
- reg_we_i  in  1  write-back write enable.
- reg_waddr_i  in  5  write-back address.
- reg_wdata_i  in  32  write-back data.
- dbg_req_i  in  1  debug request; held until acknowledged.
- dbg_we_i  in  1  debug access type: 1 = write, 0 = read.
- dbg_addr_i  in  5  debug register index.
- dbg_wdata_i  in  32  debug write data.
- dbg_ack_o  out  1  one-cycle debug completion pulse.
- dbg_rdata_o  out  32  debug read data; valid while dbg_ack_o = 1, then held.
- ready_o  out  1  1 once the init sweep is done and the pipeline may run.

## Operation
- States: INIT, IDLE, ACK.
- Reset (rst_i = 0 at an edge):
  - state = INIT, init counter = INIT_FIRST.
  - ready_o = 0, dbg_ack_o = 0, dbg_rdata_o = `ZeroWord`.
- INIT:
  - Each edge writes `ZeroWord` to reg[cnt], then cnt+1.
  - The edge that writes INIT_LAST moves to IDLE and sets ready_o = 1.
  - Write-back writes and debug requests are ignored.
  - Both read ports return `ZeroWord`.
- Read ports (any state after INIT), checked in this order:
  - re = 0 -> `ZeroWord`.
  - addr = 0 -> `ZeroWord`.
  - Otherwise reg[addr], subject to the bypass rule under Configuration.
- Write-back: when reg_we_i = 1, ready_o = 1 and reg_waddr_i != 0, reg[reg_waddr_i] <= reg_wdata_i at the edge. Writes to x0 are dropped.
- IDLE with dbg_req_i = 1:
  - Read: capture dbg_rdata_o <= reg[dbg_addr_i] (x0 reads 0) and go to ACK.
  - Write with reg_we_i = 0: reg[dbg_addr_i] <= dbg_wdata_i (x0 dropped) and go to ACK.
  - Write with reg_we_i = 1: stall in IDLE. Write-back has priority; no ack, no debug write.
- ACK:
  - dbg_ack_o = 1 for exactly this cycle; next edge returns to IDLE.
  - dbg_req_i still 1 on the following IDLE edge is a new request.
- Debug read in the same cycle as a write-back to the same index captures the old value.
- Reset mid-operation: the pending debug transaction is dropped with no ack, and the INIT sweep restarts from INIT_FIRST.

## Timing
- Read ports: zero latency, combinational from address/enable (plus write-back inputs when bypass is compiled in).
- Write-back visible to a plain read on the cycle after the write edge.
- ready_o rises after INIT_LAST-INIT_FIRST+1 edges with rst_i = 1: 31 edges at default parameters.
- Debug latency, request seen in IDLE -> dbg_ack_o high the next cycle. Minimum 1 cycle; a write is extended by each cycle reg_we_i = 1.
- Debug throughput: at most one transaction per 2 cycles.
- dbg_rdata_o changes only at read capture or reset.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - Read port i returns reg_wdata_i when reg_we_i = 1, reg_waddr_i = raddr, raddr != 0, re = 1 and ready_o = 1.
  - This forwards write-back to decode in the same cycle.
  - Affects the pipeline read ports only, not the debug read.
- Undefined: read ports always return the stored value, so a same-cycle write is seen one cycle later.

## Test plan
- Reset 3 cycles, then release -> ready_o = 0 for 30 cycles, 1 on the 31st edge; reads of x1..x31 all return 0x00000000.
- Write-back x5 = 0xDEADBEEF, then read port 1 addr 5 re = 1 next cycle -> 0xDEADBEEF. Same read with re = 0 -> 0x00000000. Write x0 = 0x12345678 then read x0 -> 0x00000000.
- Same-cycle write-back x7 = 0xA5A5A5A5 with read port 2 addr 7 (x7 previously 0x1) -> 0xA5A5A5A5 with `REGFILE_BYPASS_EN`, 0x00000001 without.
- Debug write x9 = 0xCAFEF00D while reg_we_i = 1 for 3 cycles -> no ack for 3 cycles, ack on the 4th cycle after the first stalled cycle. Debug read x9 afterwards -> ack next cycle, dbg_rdata_o = 0xCAFEF00D.
- Debug read x3 in the same cycle as write-back x3 = 0x55 (old value 0x11) -> dbg_rdata_o = 0x00000011; a following pipeline read returns 0x00000055.
- Assert rst_i low during ACK and during INIT (cnt = 12) -> dbg_ack_o = 0 next cycle, ready_o = 0, full 31-cycle sweep restarts; x20 written before reset reads 0 afterward.

Source files
------------

// File: rtl/regfile.sv
// regfile: 32 x 32-bit RISC-V integer register file.
// Two combinational read ports for decode and one write-back port.
// A sequential zeroing sweep runs after reset so the storage can map to
// distributed RAM. A request/acknowledge debug port is also provided.
// Optional feature macro: REGFILE_BYPASS_EN forwards same-cycle write-back
// data to the pipeline read ports.
module regfile #(
    parameter int INIT_FIRST = 1,
    parameter int INIT_LAST  = 31
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  reg1_raddr_i,
    input  logic        reg1_re_i,
    output logic [31:0] reg1_rdata_o,
    input  logic [4:0]  reg2_raddr_i,
    input  logic        reg2_re_i,
    output logic [31:0] reg2_rdata_o,
    input  logic        reg_we_i,
    input  logic [4:0]  reg_waddr_i,
    input  logic [31:0] reg_wdata_i,
    input  logic        dbg_req_i,
    input  logic        dbg_we_i,
    input  logic [4:0]  dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    output logic        dbg_ack_o,
    output logic [31:0] dbg_rdata_o,
    output logic        ready_o
);

    localparam logic        RST_ENABLE = 1'b0;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
    localparam logic [4:0]  FIRST_IDX  = INIT_FIRST[4:0];
    localparam logic [4:0]  LAST_IDX   = INIT_LAST[4:0];

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [4:0]  cnt_r;
    logic        ready_r;
    logic        ack_r;
    logic [31:0] dbg_rdata_r;

    logic [31:0] mem_r [0:31];

    // Single physical write port shared by the init sweep, write-back and debug.
    logic        wen_s;
    logic [4:0]  waddr_s;
    logic [31:0] wdata_s;

    logic        wb_write_s;
    logic        dbg_idle_req_s;
    logic        dbg_write_s;
    logic        dbg_read_s;
    logic [31:0] dbg_read_value_s;

    // Qualify write-back and debug requests against the current state.
    always_comb begin
        wb_write_s       = 1'b0;
        dbg_idle_req_s   = 1'b0;
        dbg_write_s      = 1'b0;
        dbg_read_s       = 1'b0;
        dbg_read_value_s = ZERO_WORD;
        if (ready_r && reg_we_i && (reg_waddr_i != 5'd0)) begin
            wb_write_s = 1'b1;
        end else begin
            wb_write_s = 1'b0;
        end
        if ((state_r == ST_IDLE) && dbg_req_i) begin
            dbg_idle_req_s = 1'b1;
        end else begin
            dbg_idle_req_s = 1'b0;
        end
        // A debug write waits while write-back owns the write port.
        if (dbg_idle_req_s && dbg_we_i && !reg_we_i && (dbg_addr_i != 5'd0)) begin
            dbg_write_s = 1'b1;
        end else begin
            dbg_write_s = 1'b0;
        end
        if (dbg_idle_req_s && !dbg_we_i) begin
            dbg_read_s = 1'b1;
        end else begin
            dbg_read_s = 1'b0;
        end
        // Debug reads see the stored value only, never the bypass path.
        if (dbg_addr_i == 5'd0) begin
            dbg_read_value_s = ZERO_WORD;
        end else begin
            dbg_read_value_s = mem_r[dbg_addr_i];
        end
    end

    // Select the source for the single storage write port.
    always_comb begin
        wen_s   = 1'b0;
        waddr_s = 5'd0;
        wdata_s = ZERO_WORD;
        if (rst_i == RST_ENABLE) begin
            wen_s = 1'b0;
        end else if (state_r == ST_INIT) begin
            wen_s   = 1'b1;
            waddr_s = cnt_r;
            wdata_s = ZERO_WORD;
        end else if (wb_write_s) begin
            wen_s   = 1'b1;
            waddr_s = reg_waddr_i;
            wdata_s = reg_wdata_i;
        end else if (dbg_write_s) begin
            wen_s   = 1'b1;
            waddr_s = dbg_addr_i;
            wdata_s = dbg_wdata_i;
        end else begin
            wen_s = 1'b0;
        end
    end

    // Storage array: no reset so it maps onto distributed RAM.
    always_ff @(posedge clk_i) begin
        if (wen_s) begin
            mem_r[waddr_s] <= wdata_s;
        end
    end

    // Next-state logic for the init / idle / acknowledge controller.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (cnt_r == LAST_IDX) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (dbg_read_s) begin
                    next_state_s = ST_ACK;
                end else if (dbg_idle_req_s && dbg_we_i && !reg_we_i) begin
                    next_state_s = ST_ACK;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACK: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_INIT;
            end
        endcase
    end

    // Controller state, sweep counter and registered status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i == RST_ENABLE) begin
            state_r     <= ST_INIT;
            cnt_r       <= FIRST_IDX;
            ready_r     <= 1'b0;
            ack_r       <= 1'b0;
            dbg_rdata_r <= ZERO_WORD;
        end else begin
            state_r <= next_state_s;
            ack_r   <= (next_state_s == ST_ACK);
            if (state_r == ST_INIT) begin
                if (cnt_r == LAST_IDX) begin
                    ready_r <= 1'b1;
                end else begin
                    cnt_r <= cnt_r + 5'd1;
                end
            end
            if (dbg_read_s) begin
                dbg_rdata_r <= dbg_read_value_s;
            end
        end
    end

    // Pipeline read port 1: zero when not ready, disabled or x0.
    always_comb begin
        reg1_rdata_o = ZERO_WORD;
        if (!ready_r) begin
            reg1_rdata_o = ZERO_WORD;
        end else if (!reg1_re_i) begin
            reg1_rdata_o = ZERO_WORD;
        end else if (reg1_raddr_i == 5'd0) begin
            reg1_rdata_o = ZERO_WORD;
`ifdef REGFILE_BYPASS_EN
        end else if (reg_we_i && (reg_waddr_i == reg1_raddr_i)) begin
            reg1_rdata_o = reg_wdata_i;
`endif
        end else begin
            reg1_rdata_o = mem_r[reg1_raddr_i];
        end
    end

    // Pipeline read port 2: zero when not ready, disabled or x0.
    always_comb begin
        reg2_rdata_o = ZERO_WORD;
        if (!ready_r) begin
            reg2_rdata_o = ZERO_WORD;
        end else if (!reg2_re_i) begin
            reg2_rdata_o = ZERO_WORD;
        end else if (reg2_raddr_i == 5'd0) begin
            reg2_rdata_o = ZERO_WORD;
`ifdef REGFILE_BYPASS_EN
        end else if (reg_we_i && (reg_waddr_i == reg2_raddr_i)) begin
            reg2_rdata_o = reg_wdata_i;
`endif
        end else begin
            reg2_rdata_o = mem_r[reg2_raddr_i];
        end
    end

    assign dbg_ack_o   = ack_r;
    assign dbg_rdata_o = dbg_rdata_r;
    assign ready_o     = ready_r;

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: init sweep, vector table, debug corner
// sequences, reset recovery and randomized traffic against an array model.
module tb_regfile;

    logic        clk_i;
    logic        rst_i;
    logic [4:0]  reg1_raddr_i;
    logic        reg1_re_i;
    logic [31:0] reg1_rdata_o;
    logic [4:0]  reg2_raddr_i;
    logic        reg2_re_i;
    logic [31:0] reg2_rdata_o;
    logic        reg_we_i;
    logic [4:0]  reg_waddr_i;
    logic [31:0] reg_wdata_i;
    logic        dbg_req_i;
    logic        dbg_we_i;
    logic [4:0]  dbg_addr_i;
    logic [31:0] dbg_wdata_i;
    logic        dbg_ack_o;
    logic [31:0] dbg_rdata_o;
    logic        ready_o;

    int passed = 0;
    int total  = 0;

    logic [31:0] model [0:31];

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        re1;
        logic [4:0]  raddr1;
        logic        re2;
        logic [4:0]  raddr2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [7];

    regfile dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .reg1_raddr_i (reg1_raddr_i),
        .reg1_re_i    (reg1_re_i),
        .reg1_rdata_o (reg1_rdata_o),
        .reg2_raddr_i (reg2_raddr_i),
        .reg2_re_i    (reg2_re_i),
        .reg2_rdata_o (reg2_rdata_o),
        .reg_we_i     (reg_we_i),
        .reg_waddr_i  (reg_waddr_i),
        .reg_wdata_i  (reg_wdata_i),
        .dbg_req_i    (dbg_req_i),
        .dbg_we_i     (dbg_we_i),
        .dbg_addr_i   (dbg_addr_i),
        .dbg_wdata_i  (dbg_wdata_i),
        .dbg_ack_o    (dbg_ack_o),
        .dbg_rdata_o  (dbg_rdata_o),
        .ready_o      (ready_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        reg1_raddr_i = 5'd0; reg1_re_i = 1'b0;
        reg2_raddr_i = 5'd0; reg2_re_i = 1'b0;
        reg_we_i = 1'b0; reg_waddr_i = 5'd0; reg_wdata_i = 32'h0;
        dbg_req_i = 1'b0; dbg_we_i = 1'b0; dbg_addr_i = 5'd0; dbg_wdata_i = 32'h0;
    endtask

    // Count edges (rst_i high) until ready_o rises, bounded.
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ready_o && n < 40) begin
            tick();
            n++;
        end
        check(name, 32'(n), 32'd31);
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        reg_we_i = 1'b1; reg_waddr_i = a; reg_wdata_i = d;
        tick();
        reg_we_i = 1'b0;
        if (a != 5'd0) model[a] = d;
    endtask

    task automatic read1(input string name, input logic [4:0] a, input logic [31:0] exp);
        reg1_re_i = 1'b1; reg1_raddr_i = a;
        #1;
        check(name, reg1_rdata_o, exp);
        reg1_re_i = 1'b0;
    endtask

    initial begin
        logic [31:0] e1;
        logic [31:0] e2;
        idle_inputs();
        rst_i = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        // Reset for three edges.
        tick(); tick(); tick();
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_ack", 32'(dbg_ack_o), 32'd0);
        check("rst_rdata", dbg_rdata_o, 32'h0);
        rst_i = 1'b1;
        read1("init_read_zero", 5'd5, 32'h0);
        wait_ready("init_edges");
        for (int a = 1; a < 32; a++) begin
            reg1_re_i = 1'b1; reg1_raddr_i = 5'(a);
            reg2_re_i = 1'b1; reg2_raddr_i = 5'(32 - a);
            #1;
            check("swept_p1", reg1_rdata_o, 32'h0);
            check("swept_p2", reg2_rdata_o, 32'h0);
        end
        idle_inputs();

        // Vector table: reads never hit the same-cycle write address.
        vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd1,  1'b1, 5'd2,  32'h0,        32'h0};
        vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b0, 5'd5,  32'hDEADBEEF, 32'h0};
        vecs[2] = '{1'b1, 5'd0,  32'h12345678, 1'b1, 5'd5,  1'b1, 5'd0,  32'hDEADBEEF, 32'h0};
        vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd5,  32'h0,        32'hDEADBEEF};
        vecs[4] = '{1'b1, 5'd7,  32'h00000001, 1'b1, 5'd5,  1'b1, 5'd1,  32'hDEADBEEF, 32'h0};
        vecs[5] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd7,  1'b1, 5'd0,  32'h00000001, 32'h0};
        vecs[6] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 1'b1, 5'd7,  32'hFFFFFFFF, 32'h00000001};
        for (int i = 0; i < 7; i++) begin
            reg_we_i = vecs[i].we; reg_waddr_i = vecs[i].waddr; reg_wdata_i = vecs[i].wdata;
            reg1_re_i = vecs[i].re1; reg1_raddr_i = vecs[i].raddr1;
            reg2_re_i = vecs[i].re2; reg2_raddr_i = vecs[i].raddr2;
            #1;
            check($sformatf("vec%0d_p1", i), reg1_rdata_o, vecs[i].exp1);
            check($sformatf("vec%0d_p2", i), reg2_rdata_o, vecs[i].exp2);
            tick();
            if (vecs[i].we && vecs[i].waddr != 5'd0) model[vecs[i].waddr] = vecs[i].wdata;
        end
        idle_inputs();

        // Same-cycle write-back and read of x7 (holds 0x1).
        reg_we_i = 1'b1; reg_waddr_i = 5'd7; reg_wdata_i = 32'hA5A5A5A5;
        reg2_re_i = 1'b1; reg2_raddr_i = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("same_cycle_x7", reg2_rdata_o, 32'hA5A5A5A5);
`else
        check("same_cycle_x7", reg2_rdata_o, 32'h00000001);
`endif
        tick();
        model[7] = 32'hA5A5A5A5;
        reg_we_i = 1'b0;
        #1;
        check("next_cycle_x7", reg2_rdata_o, 32'hA5A5A5A5);
        idle_inputs();

        // Debug write stalled by three write-back cycles.
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd9; dbg_wdata_i = 32'hCAFEF00D;
        reg_we_i = 1'b1; reg_waddr_i = 5'd10; reg_wdata_i = 32'h0000_0A0A;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_noack%0d", i), 32'(dbg_ack_o), 32'd0);
        end
        model[10] = 32'h0000_0A0A;
        reg_we_i = 1'b0;
        tick();
        check("dbg_wr_ack", 32'(dbg_ack_o), 32'd1);
        dbg_req_i = 1'b0;
        tick();
        check("dbg_wr_ack_drop", 32'(dbg_ack_o), 32'd0);
        model[9] = 32'hCAFEF00D;
        read1("x10_wb_during_stall", 5'd10, 32'h0000_0A0A);

        // Debug read of x9.
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd9;
        tick();
        check("dbg_rd_ack", 32'(dbg_ack_o), 32'd1);
        check("dbg_rd_data", dbg_rdata_o, 32'hCAFEF00D);
        dbg_req_i = 1'b0;
        tick();
        check("dbg_rd_ack_drop", 32'(dbg_ack_o), 32'd0);
        check("dbg_rd_held", dbg_rdata_o, 32'hCAFEF00D);

        // Debug read racing a write-back to the same index.
        wb_write(5'd3, 32'h11);
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd3;
        reg_we_i = 1'b1; reg_waddr_i = 5'd3; reg_wdata_i = 32'h55;
        tick();
        model[3] = 32'h55;
        check("race_ack", 32'(dbg_ack_o), 32'd1);
        check("race_old_value", dbg_rdata_o, 32'h11);
        dbg_req_i = 1'b0; reg_we_i = 1'b0;
        read1("race_new_value", 5'd3, 32'h55);
        tick();

        // Reset while in ACK.
        wb_write(5'd20, 32'h2020_2020);
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd20;
        tick();
        check("pre_rst_ack", 32'(dbg_ack_o), 32'd1);
        dbg_req_i = 1'b0;
        rst_i = 1'b0;
        tick();
        check("rst_ack_dropped", 32'(dbg_ack_o), 32'd0);
        check("rst_ack_ready", 32'(ready_o), 32'd0);
        check("rst_ack_rdata", dbg_rdata_o, 32'h0);
        rst_i = 1'b1;

        // Reset again mid-sweep (counter at 12), debug request ignored in INIT.
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd4; dbg_wdata_i = 32'hBAD0BAD0;
        for (int i = 0; i < 11; i++) tick();
        check("mid_init_noack", 32'(dbg_ack_o), 32'd0);
        dbg_req_i = 1'b0;
        rst_i = 1'b0;
        tick();
        check("mid_init_ready", 32'(ready_o), 32'd0);
        rst_i = 1'b1;
        wait_ready("resweep_edges");
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        read1("x20_cleared", 5'd20, 32'h0);
        read1("x4_cleared", 5'd4, 32'h0);

        // Randomized pipeline traffic against the array model.
        for (int c = 0; c < 400; c++) begin
            reg_we_i     = 1'($urandom_range(0, 1));
            reg_waddr_i  = 5'($urandom_range(0, 31));
            reg_wdata_i  = $urandom;
            reg1_re_i    = ($urandom_range(0, 3) != 0);
            reg1_raddr_i = 5'($urandom_range(0, 31));
            reg2_re_i    = ($urandom_range(0, 3) != 0);
            reg2_raddr_i = (c % 4 == 0) ? reg_waddr_i : 5'($urandom_range(0, 31));
            e1 = (!reg1_re_i || reg1_raddr_i == 5'd0) ? 32'h0 : model[reg1_raddr_i];
            e2 = (!reg2_re_i || reg2_raddr_i == 5'd0) ? 32'h0 : model[reg2_raddr_i];
`ifdef REGFILE_BYPASS_EN
            if (reg1_re_i && reg_we_i && reg1_raddr_i != 5'd0 && reg1_raddr_i == reg_waddr_i) e1 = reg_wdata_i;
            if (reg2_re_i && reg_we_i && reg2_raddr_i != 5'd0 && reg2_raddr_i == reg_waddr_i) e2 = reg_wdata_i;
`endif
            #1;
            check("rand_p1", reg1_rdata_o, e1);
            check("rand_p2", reg2_rdata_o, e2);
            tick();
            if (reg_we_i && reg_waddr_i != 5'd0) model[reg_waddr_i] = reg_wdata_i;
        end
        idle_inputs();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
